pushbutton_conditioner: RTL

//  Input stage directly upstream of the uP pushbuttons[3:0] port.
//  Per bit: synchronises raw board buttons with 2 flops, then debounces them with a counter.

---
 rtl/pushbutton_conditioner.sv | 100 ++++++++++
 1 files changed

// File: rtl/pushbutton_conditioner.sv
// pushbutton_conditioner
// Two-flop synchroniser plus per-bit debounce counter for raw board buttons.
// Presents a clean level nibble and per-button press events to the uP.
// Build option: define PB_EVENT_LATCH_EN to make pb_event sticky until rd_ack.
// Without it, pb_event is a one-cycle pulse per press and rd_ack is ignored.

module pushbutton_conditioner #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pb_raw,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] pb_clean,
    output logic [WIDTH-1:0] pb_event,
    output logic             pb_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] cnt_done;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] event_next;

    // Two-stage synchroniser; only s2 is safe to use downstream.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pb_raw;
            s2 <= s1;
        end
    end

    // Terminal-count decode and press detection (the edge where pb_clean goes 0->1).
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value held and infer a latch.
    always_comb begin
        cnt_done = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_done[i] = (cnt[i] == CNT_MAX);
        end
        rise = s2 & ~pb_clean & cnt_done;
    end

    // Per-bit debounce: a new level must be seen DB_CYCLES consecutive cycles.
    // NOTE: the counter array is reset explicitly because reset must abandon any
    // in-progress debounce; it is a handful of flops, not a RAM.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (reset) begin
                cnt[i]      <= '0;
                pb_clean[i] <= 1'b0;
            end else if (s2[i] == pb_clean[i]) begin
                cnt[i] <= '0;
            end else if (cnt_done[i]) begin
                pb_clean[i] <= s2[i];
                cnt[i]      <= '0;
            end else begin
                cnt[i] <= cnt[i] + CNT_ONE;
            end
        end
    end

`ifdef PB_EVENT_LATCH_EN
    // Sticky events: rd_ack clears, a new press in the same cycle wins.
    always_comb begin
        event_next = (pb_event & ~{WIDTH{rd_ack}}) | rise;
    end
`else
    logic unused_rd_ack;
    assign unused_rd_ack = rd_ack;

    // Pulse events: one cycle per press, acknowledge not needed.
    always_comb begin
        event_next = rise;
    end
`endif

    // Event register; pb_valid is decoded from it so it cannot glitch.
    always_ff @(posedge clock) begin
        if (reset) begin
            pb_event <= '0;
        end else begin
            pb_event <= event_next;
        end
    end

    assign pb_valid = |pb_event;

endmodule
